// File: rtl/dds_sweep_ctrl_pkg.sv
// dds_sweep_ctrl shared constants: register map, FSM encoding, helpers.
// Optional feature macro: DDS_SWEEP_BIDIR_EN (down sweeps via CTRL bit2).
package dds_sweep_ctrl_pkg;

  localparam logic [7:0] DDS_FWORD_L   = 8'h00;
  localparam logic [7:0] DDS_FWORD_H   = 8'h01;
  localparam logic [7:0] DDS_PWORD     = 8'h02;
  localparam logic [7:0] SWEEP_START_L = 8'h10;
  localparam logic [7:0] SWEEP_START_H = 8'h11;
  localparam logic [7:0] SWEEP_STEP_L  = 8'h12;
  localparam logic [7:0] SWEEP_STEP_H  = 8'h13;
  localparam logic [7:0] SWEEP_STOP_L  = 8'h14;
  localparam logic [7:0] SWEEP_STOP_H  = 8'h15;
  localparam logic [7:0] SWEEP_DWELL   = 8'h16;
  localparam logic [7:0] SWEEP_CTRL    = 8'h17;

  localparam logic [15:0] DWELL_RST = 16'd1000;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_L  = 3'd1,
    WR_H  = 3'd2,
    DWELL = 3'd3,
    STEP  = 3'd4
  } state_t;

  function automatic logic [15:0] dwell_load(input logic [15:0] d);
    return (d == 16'd0) ? 16'd1 : d;
  endfunction

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Host register bus in, DDS register bus out, plus sweep status.
// Optional feature macro: DDS_SWEEP_BIDIR_EN (no effect on this file).
interface dds_sweep_ctrl_if;

  logic        m_wr;
  logic [7:0]  m_addr;
  logic [15:0] m_wrdata;
  logic        d_wr;
  logic [7:0]  d_addr;
  logic [15:0] d_wrdata;
  logic        sweep_busy;
  logic        sweep_done;
  logic        point_flag;

  modport master (
    output m_wr, m_addr, m_wrdata,
    input  d_wr, d_addr, d_wrdata,
    input  sweep_busy, sweep_done, point_flag
  );

  modport slave (
    input  m_wr, m_addr, m_wrdata,
    output d_wr, d_addr, d_wrdata,
    output sweep_busy, sweep_done, point_flag
  );

endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep scheduler; host writes pass through and win the bus.
// Optional feature macro: DDS_SWEEP_BIDIR_EN (CTRL bit2 = down sweep).
module dds_sweep_ctrl
  import dds_sweep_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  dds_sweep_ctrl_if.slave  bus
);

  state_t      state;
  logic [31:0] start_r, step_r, stop_r, cur;
  logic [15:0] dwell_r, cnt;
  logic        cont_r, abort_q;
  logic        ctrl_wr, run_wr, abort;
  logic [32:0] nxt;
  logic        stop_hit;
`ifdef DDS_SWEEP_BIDIR_EN
  logic        dir_r;
`endif

  assign ctrl_wr = bus.m_wr && (bus.m_addr == SWEEP_CTRL);
  assign run_wr  = ctrl_wr && bus.m_wrdata[0];
  assign abort   = ctrl_wr && !bus.m_wrdata[0];

  always_comb begin
    nxt      = {1'b0, cur} + {1'b0, step_r};
    stop_hit = nxt[32] || (nxt[31:0] > stop_r) || (step_r == 32'd0);
`ifdef DDS_SWEEP_BIDIR_EN
    if (dir_r) begin
      nxt      = {1'b0, cur} - {1'b0, step_r};
      stop_hit = nxt[32] || (nxt[31:0] < stop_r) || (step_r == 32'd0);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_r <= '0;
      step_r  <= '0;
      stop_r  <= '0;
      dwell_r <= DWELL_RST;
      cont_r  <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      dir_r   <= 1'b0;
`endif
    end else if (bus.m_wr) begin
      case (bus.m_addr)
        SWEEP_START_L: start_r[15:0]  <= bus.m_wrdata;
        SWEEP_START_H: start_r[31:16] <= bus.m_wrdata;
        SWEEP_STEP_L:  step_r[15:0]   <= bus.m_wrdata;
        SWEEP_STEP_H:  step_r[31:16]  <= bus.m_wrdata;
        SWEEP_STOP_L:  stop_r[15:0]   <= bus.m_wrdata;
        SWEEP_STOP_H:  stop_r[31:16]  <= bus.m_wrdata;
        SWEEP_DWELL:   dwell_r        <= bus.m_wrdata;
        SWEEP_CTRL: begin
          cont_r <= bus.m_wrdata[1];
`ifdef DDS_SWEEP_BIDIR_EN
          dir_r  <= bus.m_wrdata[2];
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      cur            <= '0;
      cnt            <= '0;
      abort_q        <= 1'b0;
      bus.d_wr       <= 1'b0;
      bus.d_addr     <= '0;
      bus.d_wrdata   <= '0;
      bus.sweep_busy <= 1'b0;
      bus.sweep_done <= 1'b0;
      bus.point_flag <= 1'b0;
    end else begin
      bus.d_wr       <= bus.m_wr;
      bus.sweep_done <= 1'b0;
      bus.point_flag <= 1'b0;
      if (bus.m_wr) begin
        bus.d_addr   <= bus.m_addr;
        bus.d_wrdata <= bus.m_wrdata;
      end
      if (run_wr) begin
        state          <= WR_L;
        cur            <= start_r;
        abort_q        <= 1'b0;
        bus.sweep_busy <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          WR_L: begin
            if (abort) begin
              state          <= IDLE;
              bus.sweep_busy <= 1'b0;
            end else if (!bus.m_wr) begin
              bus.d_wr     <= 1'b1;
              bus.d_addr   <= DDS_FWORD_L;
              bus.d_wrdata <= cur[15:0];
              state        <= WR_H;
            end
          end
          WR_H: begin
            // an abort here still lets the H half land first
            if (bus.m_wr) begin
              if (abort) abort_q <= 1'b1;
            end else begin
              bus.d_wr       <= 1'b1;
              bus.d_addr     <= DDS_FWORD_H;
              bus.d_wrdata   <= cur[31:16];
              bus.point_flag <= 1'b1;
              if (abort_q) begin
                state          <= IDLE;
                abort_q        <= 1'b0;
                bus.sweep_busy <= 1'b0;
              end else begin
                state <= DWELL;
                cnt   <= dwell_load(dwell_r);
              end
            end
          end
          DWELL: begin
            if (abort) begin
              state          <= IDLE;
              bus.sweep_busy <= 1'b0;
            end else if (cnt <= 16'd1) begin
              state <= STEP;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          STEP: begin
            if (abort) begin
              state          <= IDLE;
              bus.sweep_busy <= 1'b0;
            end else if (stop_hit) begin
              if (cont_r) begin
                cur   <= start_r;
                state <= WR_L;
              end else begin
                state          <= IDLE;
                bus.sweep_busy <= 1'b0;
                bus.sweep_done <= 1'b1;
              end
            end else begin
              cur   <= nxt[31:0];
              state <= WR_L;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: expected DDS writes queued, monitor pops.
// Optional feature macro: DDS_SWEEP_BIDIR_EN (adds the down-sweep case).
module tb_dds_sweep_ctrl;
  import dds_sweep_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dds_sweep_ctrl_if bus ();

  dds_sweep_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors  = 0;
  int errors   = 0;
  int cyc      = 0;
  int ctrl_cyc = 0;
  int done_cnt = 0;
  int pf_cnt   = 0;
  logic [23:0] exq[$];
  int lcyc[$];
  logic [23:0] e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.d_wr) begin
        if (exq.size() == 0) begin
          vectors++;
          errors++;
          $display("FAIL unexpected_write: got %0h, expected none",
                   {bus.d_addr, bus.d_wrdata});
        end else begin
          e = exq.pop_front();
          check("dds_write", {8'h0, bus.d_addr, bus.d_wrdata}, {8'h0, e});
        end
        if (bus.d_addr == DDS_FWORD_L) lcyc.push_back(cyc);
        if (bus.d_addr == SWEEP_CTRL) ctrl_cyc = cyc;
      end
      if (bus.sweep_done) begin
        done_cnt++;
        check("busy_low_at_done", bus.sweep_busy, 0);
      end
      if (bus.point_flag) pf_cnt++;
    end
  end

  task automatic drive(logic [7:0] a, logic [15:0] d);
    bus.m_wr     = 1'b1;
    bus.m_addr   = a;
    bus.m_wrdata = d;
    @(posedge clk);
    #1;
    bus.m_wr = 1'b0;
  endtask

  task automatic wr(logic [7:0] a, logic [15:0] d);
    exq.push_back({a, d});
    drive(a, d);
  endtask

  task automatic exp_pt(logic [31:0] v);
    exq.push_back({DDS_FWORD_L, v[15:0]});
    exq.push_back({DDS_FWORD_H, v[31:16]});
  endtask

  task automatic setp(logic [31:0] st, logic [31:0] sp,
                      logic [31:0] so, logic [15:0] dw);
    wr(SWEEP_START_L, st[15:0]);
    wr(SWEEP_START_H, st[31:16]);
    wr(SWEEP_STEP_L, sp[15:0]);
    wr(SWEEP_STEP_H, sp[31:16]);
    wr(SWEEP_STOP_L, so[15:0]);
    wr(SWEEP_STOP_H, so[31:16]);
    wr(SWEEP_DWELL, dw);
  endtask

  task automatic settle(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_done(string name, int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_done_count"}, done_cnt - d0, 1);
    settle(10);
    check({name, "_queue_drained"}, exq.size(), 0);
    check({name, "_no_extra_done"}, done_cnt - d0, 1);
  endtask

  task automatic wait_q(string name, int sz, int budget);
    int n = 0;
    while (exq.size() != sz && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_reached"}, exq.size(), sz);
  endtask

  initial begin
    int d0, p0;
    bus.m_wr     = 1'b0;
    bus.m_addr   = '0;
    bus.m_wrdata = '0;
    settle(3);
    check("rst_d_wr", bus.d_wr, 0);
    check("rst_d_bus", {bus.d_addr, bus.d_wrdata}, 0);
    check("rst_status",
          {bus.sweep_busy, bus.sweep_done, bus.point_flag}, 0);
    rst = 1'b1;
    settle(2);

    // one-shot 100..250 step 50, dwell 4
    setp(32'd100, 32'd50, 32'd250, 16'd4);
    lcyc.delete();
    p0 = pf_cnt;
    wr(SWEEP_CTRL, 16'h0001);
    check("busy_after_start", bus.sweep_busy, 1);
    exp_pt(32'd100);
    exp_pt(32'd150);
    exp_pt(32'd200);
    exp_pt(32'd250);
    wait_done("oneshot", 100);
    check("oneshot_points", lcyc.size(), 4);
    check("oneshot_point_flags", pf_cnt - p0, 4);
    if (lcyc.size() == 4) begin
      check("first_L_latency", lcyc[0] - ctrl_cyc, 1);
      for (int i = 1; i < 4; i++)
        check("point_period", lcyc[i] - lcyc[i-1], 7);
    end

    // continuous wraps to START, abort landing in WR_H
    d0 = done_cnt;
    wr(SWEEP_CTRL, 16'h0003);
    exp_pt(32'd100);
    exp_pt(32'd150);
    exp_pt(32'd200);
    exp_pt(32'd250);
    exp_pt(32'd100);
    wait_q("cont_wrap", 1, 200);
    exq.push_front({SWEEP_CTRL, 16'h0000});
    drive(SWEEP_CTRL, 16'h0000);
    settle(10);
    check("abort_queue_drained", exq.size(), 0);
    check("abort_busy_low", bus.sweep_busy, 0);
    check("abort_no_done", done_cnt - d0, 0);

    // host PWORD write collides with the first WR_L
    lcyc.delete();
    wr(SWEEP_CTRL, 16'h0001);
    wr(DDS_PWORD, 16'h1234);
    exp_pt(32'd100);
    exp_pt(32'd150);
    exp_pt(32'd200);
    exp_pt(32'd250);
    wait_done("collide", 100);
    check("collide_points", lcyc.size(), 4);
    if (lcyc.size() > 0)
      check("collide_L_delay", lcyc[0] - ctrl_cyc, 2);

    // carry out of the 32-bit add ends the sweep
    setp(32'hFFFF_FF00, 32'h200, 32'hFFFF_FFFF, 16'd4);
    wr(SWEEP_CTRL, 16'h0001);
    exp_pt(32'hFFFF_FF00);
    wait_done("carry", 60);

    // STEP = 0
    setp(32'd100, 32'd0, 32'd250, 16'd4);
    wr(SWEEP_CTRL, 16'h0001);
    exp_pt(32'd100);
    wait_done("step_zero", 60);

    // START above STOP
    setp(32'd300, 32'd50, 32'd200, 16'd4);
    wr(SWEEP_CTRL, 16'h0001);
    exp_pt(32'd300);
    wait_done("start_gt_stop", 60);

`ifdef DDS_SWEEP_BIDIR_EN
    setp(32'd250, 32'd50, 32'd100, 16'd4);
    wr(SWEEP_CTRL, 16'h0005);
    exp_pt(32'd250);
    exp_pt(32'd200);
    exp_pt(32'd150);
    exp_pt(32'd100);
    wait_done("down", 100);
`endif

    // reset in the middle of DWELL
    setp(32'd100, 32'd50, 32'd250, 16'd4);
    wr(SWEEP_CTRL, 16'h0001);
    exp_pt(32'd100);
    wait_q("pre_reset", 0, 50);
    settle(2);
    check("busy_before_reset", bus.sweep_busy, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_d_wr", bus.d_wr, 0);
    check("mid_rst_d_bus", {bus.d_addr, bus.d_wrdata}, 0);
    check("mid_rst_status",
          {bus.sweep_busy, bus.sweep_done, bus.point_flag}, 0);
    settle(2);
    rst = 1'b1;
    settle(30);
    check("post_reset_idle", bus.sweep_busy, 0);
    check("post_reset_queue", exq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep scheduler for the DDS register block in the uart_scope design. It sits between the UART command decoder's register bus and the DDS register block. Host writes are forwarded unchanged. When a sweep is armed, the block steps the DDS frequency word from a start value to a stop value, writing each point over the same bus. Host writes always win the bus, and sweep writes are deferred around them.

## Interface
- No parameters; addresses and widths are fixed constants from the shared header.
- clk  in  1  system clock
- rst  in  1  reset rst, asynchronous, active-low
- m_wr  in  1  host write strobe
- m_addr  in  8  host register address
- m_wrdata  in  16  host write data
- d_wr  out  1  write strobe to DDS register block, registered
- d_addr  out  8  address to DDS register block, registered
- d_wrdata  out  16  data to DDS register block, registered
- sweep_busy  out  1  high from sweep start until return to IDLE
- sweep_done  out  1  one-cycle pulse when a one-shot sweep ends
- point_flag  out  1  one-cycle pulse after each H write, marking a new point being applied

## Operation
- Sweep registers, written by host only; the host write is also forwarded to d_* (harmless to the DDS):
  - SWEEP_START_L/H, 32-bit, reset 0
  - SWEEP_STEP_L/H, 32-bit, reset 0
  - SWEEP_STOP_L/H, 32-bit, reset 0
  - SWEEP_DWELL, 16-bit, reset 1000
  - SWEEP_CTRL
- SWEEP_CTRL bits:
  - bit0: run; write 1 = start, write 0 = abort
  - bit1: continuous
  - bit2: direction down; exists only with the macro
- FSM states: IDLE, WR_L, WR_H, DWELL, STEP.
- IDLE -> WR_L on a CTRL write with bit0=1. cur is loaded with START.
- WR_L: issue DDS_FWORD_L = cur[15:0] -> WR_H.
- WR_H: issue DDS_FWORD_H = cur[31:16] -> DWELL. Pulse point_flag. Load the dwell counter with max(DWELL,1).
- DWELL: decrement the counter each cycle; at 1 -> STEP.
- STEP: compute next = cur + STEP as 33-bit unsigned.
  - If next > STOP, or carry out is set, or STEP == 0: continuous -> cur = START, go to WR_L; otherwise -> IDLE and pulse sweep_done.
  - Else cur = next, go to WR_L.
- START > STOP: the START point is written once, and the sweep then ends (or reloads START if continuous).
- Arbitration: in any cycle with m_wr=1, the host write is forwarded and the FSM holds in WR_L/WR_H for that cycle. The sweep write is retried next cycle. The DWELL counter keeps running.
- Abort (CTRL bit0=0) seen in WR_L -> IDLE immediately. Seen in WR_H -> the H write completes first, so the word is never left half-updated, then IDLE. Seen in DWELL/STEP -> IDLE next cycle. Abort never produces sweep_done.
- A CTRL bit0=1 write while busy restarts from START at WR_L.
- Writes to START/STEP/STOP/DWELL during a sweep take effect at the next STEP or dwell load.

## Timing
- Reset values: d_wr, d_addr, d_wrdata, sweep_busy, sweep_done, point_flag all 0; FSM in IDLE.
- Host write sampled at edge k appears on d_* after edge k (1-cycle latency). d_wr is otherwise 0.
- CTRL start sampled at edge k: sweep_busy=1 after edge k; the L write appears on d_* after edge k+1 and the H write after edge k+2.
- Uncontended point period = DWELL + 3 cycles (L, H, DWELL×N, STEP). Each host write collision during WR_L/WR_H adds 1 cycle.
- Between the L and H writes, the DDS runs one point's mixed word for 1 cycle. This is accepted.
- sweep_done and sweep_busy falling are on the same edge.

## Configuration
- DDS_SWEEP_BIDIR_EN defined: CTRL bit2 selects a down sweep.
  - next = cur − STEP.
  - End condition: borrow, or next < STOP.
- DDS_SWEEP_BIDIR_EN undefined: bit2 is ignored and not stored; the sweep is always upward.

## Structure
- Shared header.v holds the new addresses alongside the existing DDS_* constants: SWEEP_START_L/H, SWEEP_STEP_L/H, SWEEP_STOP_L/H, SWEEP_DWELL, SWEEP_CTRL.
- The header also holds the FSM state encodings.
- No sub-module; a single module with the register file, FSM, 33-bit adder and dwell counter.

## Test plan
- START=100, STEP=50, STOP=250, DWELL=4, one-shot -> L writes 100, 150, 200, 250, one every 7 cycles. Then sweep_done pulses once, and busy falls on the same edge.
- Same setup, continuous -> after 250 the next L write is 100. No done pulse. Abort in WR_H -> H write of the current point still issued, then IDLE.
- Host write to DDS_PWORD in the same cycle as a sweep WR_L -> PWORD forwarded first, L write delayed exactly 1 cycle.
- START=0xFFFF_FF00, STEP=0x200, STOP=0xFFFF_FFFF -> carry out detected; only 0xFFFF_FF00 is written, then done.
- STEP=0 -> START written once, then done. START=300 with STOP=200 -> 300 written once, then done.
- Reset asserted mid-DWELL -> all outputs 0 and FSM in IDLE immediately. With DDS_SWEEP_BIDIR_EN: START=250, STEP=50, STOP=100, bit2=1 -> 250, 200, 150, 100.
